nx_fifo_rd_adapter: RTL
=======================

# nx_fifo_rd_adapter

Read-side companion for the common FIFO. It drains a FIFO through its `ren`/`rdata`/`empty` port and presents the words as a registered valid/ready stream. A two-entry skid buffer absorbs the FIFO's combinational read data, so there is no combinational path from `out_ready` to `fifo_ren`. Downstream back-pressure never causes a FIFO underflow. It sits between any FIFO instance and a consumer block in the same clock domain.

## Interface
Parameters:
- `WIDTH`, 1: data width; must match the attached FIFO.
- `CNT_W`, 16: width of the delivered-word counter.
- `DATA_RESET`, 1: when 1, skid entries and `out_data` reset to 0; when 0, data registers have no reset.

Ports:
- `clk`  in  1: the only clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `clear`  in  1: synchronous flush of the skid buffer.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rdata`  in  WIDTH: FIFO head word; valid only while `fifo_empty`=0.
- `fifo_ren`  out  1: pop strobe to the FIFO.
- `out_valid`  out  1: the stream word is valid.
- `out_ready`  in  1: the consumer accepts the word.
- `out_data`  out  WIDTH: the stream word, taken from the skid head register.
- `occupancy`  out  2: number of skid entries held (0..2).
- `deliv_cnt`  out  CNT_W: count of completed output handshakes; wraps.

## Operation
- State is the occupancy `cnt`, with three states:
  - EMPTY: `cnt`=0.
  - ONE: `cnt`=1.
  - TWO: `cnt`=2.
- Storage is two entries, head (`h`) and tail (`t`). `out_data` = `h`.
- Pop rule: `fifo_ren` = !`fifo_empty` & !`clear` & (`cnt` < 2). This is a function of registered `cnt` and the FIFO flag only. It never asserts while `fifo_empty`=1.
- `push` = `fifo_ren`. The word pushed is `fifo_rdata`, sampled in the same cycle as `fifo_ren`.
- `pop` = `out_valid` & `out_ready`.
- `out_valid` = (`cnt` != 0).
- Transitions when `clear`=0:
  - EMPTY, push → ONE; `h` <= `fifo_rdata`.
  - ONE, push & !pop → TWO; `t` <= `fifo_rdata`.
  - ONE, push & pop → ONE; `h` <= `fifo_rdata`.
  - ONE, !push & pop → EMPTY.
  - TWO, pop → ONE; `h` <= `t`. No push is possible in TWO.
  - All other combinations hold state.
- `clear`=1 has priority:
  - Next state is EMPTY and `fifo_ren`=0.
  - A handshake in the same cycle still counts, so `deliv_cnt` increments.
  - Data registers are unchanged.
- `deliv_cnt` += 1 on each pop and wraps from 2^CNT_W−1 to 0.
- `occupancy` = `cnt`.
- Arithmetic: `cnt` never exceeds 2 and never underflows. A pop in EMPTY is impossible because `out_valid`=0 there.

## Timing
- Reset values:
  - `cnt`=0, so `out_valid`=0 and `fifo_ren`=0 whenever `fifo_empty`=1.
  - `occupancy`=0, `deliv_cnt`=0.
  - `out_data`=0 when `DATA_RESET`=1.
- Latency: FIFO goes non-empty in cycle N → `fifo_ren`=1 in cycle N → `out_valid`=1 in cycle N+1 with that word on `out_data`.
- Throughput: with the FIFO non-empty and `out_ready` held at 1, the block sustains one word per cycle in state ONE.
- Back-pressure: with `out_ready`=0, at most 2 words are popped, then `fifo_ren` deasserts. Popping resumes in the cycle after the first handshake.
- Handshake rules:
  - `out_data` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a handshake, except on `clear` or reset.
- Reset asserted mid-transfer: all state clears immediately (asynchronous). Skid contents are lost. The FIFO is reset by its own `rst_n`.
- `clear` in TWO: `fifo_ren`=0 that cycle and `out_valid`=0 the next cycle. If the FIFO is non-empty, popping restarts the cycle after.
- Order is strictly FIFO. No word is duplicated or dropped, other than words discarded by `clear`.

## Test plan
- **Reset:** hold `rst_n`=0 with `fifo_empty`=0 → `fifo_ren`=0, `out_valid`=0, `deliv_cnt`=0, `out_data`=0.
- **Streaming:** FIFO preloaded with words 0..7 (WIDTH=8), `out_ready`=1 → `out_valid` from cycle 1, words 0..7 on consecutive cycles, `deliv_cnt`=8, 8 `fifo_ren` pulses.
- **Back-pressure:** FIFO holds 5 words, `out_ready`=0 for 6 cycles → exactly 2 `fifo_ren` pulses, `occupancy`=2, `out_data`=word0 stable. Then release `out_ready` → remaining words arrive in order, 1 per cycle.
- **Never underflow:** random `out_ready` and random FIFO fill over 10k cycles → attached FIFO `underflow` never asserts; scoreboard matches order; `deliv_cnt` equals the number of words written.
- **Clear:** in TWO (`h`=0xA1, `t`=0xA2) assert `clear` with `out_ready`=1 → `fifo_ren`=0, `deliv_cnt` +1, next-cycle `occupancy`=0; the next word popped from the FIFO follows with no 0xA2.
- **Counter wrap:** CNT_W=4, 17 handshakes → `deliv_cnt`=1.

Source files
------------

// File: rtl/nx_fifo_rd_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nx_fifo_rd_adapter: drains a FIFO into a registered valid/ready stream      |
// | through a two-entry skid buffer.                           Revision: 1.0    |
// +----------------------------------------------------------------------------+
module nx_fifo_rd_adapter #(
  parameter int WIDTH      = 1,
  parameter int CNT_W      = 16,
  parameter bit DATA_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] deliv_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [CNT_W-1:0] deliv_cnt_q, deliv_cnt_d;
  logic             push;
  logic             pop;

  // Gated by rst_n so the attached FIFO is never popped while the block is held in reset.
  assign fifo_ren  = rst_n & ~fifo_empty & ~clear & (state_q != TWO);
  assign push      = fifo_ren;
  assign out_valid = (state_q != EMPTY);
  assign pop       = out_valid & out_ready;
  assign out_data  = h_q;
  assign occupancy = state_q;
  assign deliv_cnt = deliv_cnt_q;

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    t_d         = t_q;
    deliv_cnt_d = deliv_cnt_q;
    if (pop) begin
      deliv_cnt_d = deliv_cnt_q + CNT_W'(1);
    end
    if (clear) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            h_d     = fifo_rdata;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            t_d     = fifo_rdata;
          end else if (push && pop) begin
            h_d     = fifo_rdata;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            h_d     = t_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      deliv_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      deliv_cnt_q <= deliv_cnt_d;
    end
  end

  generate
    if (DATA_RESET) begin : g_data_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          h_q <= '0;
          t_q <= '0;
        end else begin
          h_q <= h_d;
          t_q <= t_d;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        h_q <= h_d;
        t_q <= t_d;
      end
    end
  endgenerate

endmodule
`default_nettype wire
